// File: rtl/btle_rx_packet_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the BTLE receive packet sequencer.
package btle_rx_packet_ctrl_pkg;

  localparam int unsigned HEADER_LEN_BITS   = 16;
  localparam int unsigned CRC_LEN_BITS      = 24;
  localparam int unsigned FIELD_CNT_WIDTH   = 11;

  localparam logic [FIELD_CNT_WIDTH-1:0] HdrLastIdx = FIELD_CNT_WIDTH'(HEADER_LEN_BITS - 1);
  localparam logic [FIELD_CNT_WIDTH-1:0] CrcLastIdx = FIELD_CNT_WIDTH'(CRC_LEN_BITS - 1);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StSearch  = 3'd1,
    StHeader  = 3'd2,
    StPayload = 3'd3,
    StCrc     = 3'd4
  } rx_state_e;

  // Payload length in bits for a header length field given in bytes.
  function automatic logic [FIELD_CNT_WIDTH-1:0] payload_bits(input logic [7:0] len_bytes);
    return {len_bytes, 3'b000};
  endfunction

endpackage

// File: rtl/btle_rx_packet_ctrl_search_unique_bit_sequence.sv
// Access-address correlator: slides a window over the LSB-first bit stream and
// flags, one cycle after the completing bit, when the window equals the pattern.
module search_unique_bit_sequence #(
  parameter int unsigned LEN_UNIQUE_BIT_SEQUENCE = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               phy_bit,
  input  logic                               bit_valid,
  input  logic [LEN_UNIQUE_BIT_SEQUENCE-1:0] unique_bit_sequence,
  output logic                               hit_flag
);

  // Only the previous LEN-1 bits are stored; the current bit completes the window.
  logic [LEN_UNIQUE_BIT_SEQUENCE-2:0] hist_q;
  logic [LEN_UNIQUE_BIT_SEQUENCE-1:0] window;

  // Oldest bit lands in window[0], matching an LSB-first transmitted pattern.
  assign window = {phy_bit, hist_q};

  // Shift on every valid bit and register the comparison result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q   <= '0;
      hit_flag <= 1'b0;
    end else begin
      hit_flag <= bit_valid && (window == unique_bit_sequence);
      if (bit_valid) begin
        hist_q <= window[LEN_UNIQUE_BIT_SEQUENCE-1:1];
      end
    end
  end

endmodule

// File: rtl/btle_rx_packet_ctrl.sv
// Receive packet sequencer: searches for the access address, then frames the
// header, length-driven payload and CRC, forwarding bits with per-field strobes.
module btle_rx_packet_ctrl
  import btle_rx_packet_ctrl_pkg::*;
#(
  parameter int unsigned LEN_UNIQUE_BIT_SEQUENCE = 32,
  parameter int unsigned MAX_PAYLOAD_BYTES       = 255,
  parameter int unsigned TIMEOUT_WIDTH           = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic                               stop,
  input  logic [LEN_UNIQUE_BIT_SEQUENCE-1:0] access_address,
  input  logic [TIMEOUT_WIDTH-1:0]           search_timeout,
  input  logic                               phy_bit,
  input  logic                               bit_valid,
  output logic                               busy,
  output logic                               aa_hit,
  output logic                               info_bit,
  output logic                               info_bit_valid,
  output logic                               crc_bit_valid,
  output logic [15:0]                        pdu_header,
  output logic                               header_valid,
  output logic [7:0]                         payload_len,
  output logic                               pkt_done,
  output logic                               timeout_flag,
  output logic                               len_err
);

  localparam int unsigned SrchW = $clog2(LEN_UNIQUE_BIT_SEQUENCE + 1);
  localparam logic [SrchW-1:0] SrchFull = SrchW'(LEN_UNIQUE_BIT_SEQUENCE);

  rx_state_e                  state_q, state_d;
  logic [FIELD_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [SrchW-1:0]           srch_q, srch_d;
  logic [TIMEOUT_WIDTH-1:0]   to_q, to_d, to_inc;
  logic [15:0]                hdr_d;
  logic                       busy_d, aa_hit_d, info_bit_d, info_bit_valid_d, crc_bit_valid_d;
  logic                       header_valid_d, pkt_done_d, timeout_flag_d, len_err_d;

  logic       corr_valid, corr_hit, hit_ok, timeout_hit;
  logic [7:0] len_next;

  assign corr_valid = bit_valid & (state_q == StSearch);

  search_unique_bit_sequence #(
    .LEN_UNIQUE_BIT_SEQUENCE(LEN_UNIQUE_BIT_SEQUENCE)
  ) u_search (
    .clk                 (clk),
    .rst                 (rst),
    .phy_bit             (phy_bit),
    .bit_valid           (corr_valid),
    .unique_bit_sequence (access_address),
    .hit_flag            (corr_hit)
  );

  // Stale correlator contents are ignored until a full fresh window has been fed.
  assign hit_ok      = corr_hit && (srch_q == SrchFull);
  assign to_inc      = to_q + TIMEOUT_WIDTH'(1);
  assign timeout_hit = (search_timeout != '0) && (to_inc == search_timeout);
  // Length field as it will read once the current (16th) header bit is captured.
  assign len_next    = {phy_bit, pdu_header[14:8]};
  assign payload_len = pdu_header[15:8];

  // Next-state, counter and output-pulse decode.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    srch_d           = srch_q;
    to_d             = to_q;
    hdr_d            = pdu_header;
    aa_hit_d         = 1'b0;
    info_bit_d       = info_bit;
    info_bit_valid_d = 1'b0;
    crc_bit_valid_d  = 1'b0;
    header_valid_d   = 1'b0;
    pkt_done_d       = 1'b0;
    timeout_flag_d   = 1'b0;
    len_err_d        = 1'b0;

    if (stop) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_d = StSearch;
            srch_d  = '0;
            to_d    = '0;
          end
        end
        StSearch: begin
          if (hit_ok) begin
            // A hit wins over a coinciding timeout; a bit in this cycle is header bit 0.
            state_d  = StHeader;
            aa_hit_d = 1'b1;
            cnt_d    = '0;
            if (bit_valid) begin
              hdr_d[0]         = phy_bit;
              info_bit_d       = phy_bit;
              info_bit_valid_d = 1'b1;
              cnt_d            = FIELD_CNT_WIDTH'(1);
            end
          end else if (bit_valid) begin
            if (srch_q != SrchFull) begin
              srch_d = srch_q + SrchW'(1);
            end
            to_d = to_inc;
            if (timeout_hit) begin
              state_d        = StIdle;
              timeout_flag_d = 1'b1;
            end
          end
        end
        StHeader: begin
          if (bit_valid) begin
            hdr_d[cnt_q[3:0]] = phy_bit;
            info_bit_d        = phy_bit;
            info_bit_valid_d  = 1'b1;
            cnt_d             = cnt_q + FIELD_CNT_WIDTH'(1);
            if (cnt_q == HdrLastIdx) begin
              header_valid_d = 1'b1;
              cnt_d          = '0;
              if (32'(len_next) > MAX_PAYLOAD_BYTES) begin
                state_d   = StIdle;
                len_err_d = 1'b1;
              end else if (len_next == 8'd0) begin
                state_d = StCrc;
              end else begin
                state_d = StPayload;
              end
            end
          end
        end
        StPayload: begin
          if (bit_valid) begin
            info_bit_d       = phy_bit;
            info_bit_valid_d = 1'b1;
            cnt_d            = cnt_q + FIELD_CNT_WIDTH'(1);
            if (cnt_d == payload_bits(pdu_header[15:8])) begin
              state_d = StCrc;
              cnt_d   = '0;
            end
          end
        end
        StCrc: begin
          if (bit_valid) begin
            info_bit_d      = phy_bit;
            crc_bit_valid_d = 1'b1;
            cnt_d           = cnt_q + FIELD_CNT_WIDTH'(1);
            if (cnt_q == CrcLastIdx) begin
              state_d    = StIdle;
              pkt_done_d = 1'b1;
              cnt_d      = '0;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end

    busy_d = (state_d != StIdle);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      srch_q         <= '0;
      to_q           <= '0;
      pdu_header     <= '0;
      busy           <= 1'b0;
      aa_hit         <= 1'b0;
      info_bit       <= 1'b0;
      info_bit_valid <= 1'b0;
      crc_bit_valid  <= 1'b0;
      header_valid   <= 1'b0;
      pkt_done       <= 1'b0;
      timeout_flag   <= 1'b0;
      len_err        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      srch_q         <= srch_d;
      to_q           <= to_d;
      pdu_header     <= hdr_d;
      busy           <= busy_d;
      aa_hit         <= aa_hit_d;
      info_bit       <= info_bit_d;
      info_bit_valid <= info_bit_valid_d;
      crc_bit_valid  <= crc_bit_valid_d;
      header_valid   <= header_valid_d;
      pkt_done       <= pkt_done_d;
      timeout_flag   <= timeout_flag_d;
      len_err        <= len_err_d;
    end
  end

endmodule

// File: tb/tb_btle_rx_packet_ctrl.sv
// Directed bench for btle_rx_packet_ctrl: full packets, zero length, length
// error, timeout, stale access address, stop and reset mid-packet.
module tb_btle_rx_packet_ctrl;

  localparam logic [31:0] AA = 32'h8E89BED6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [31:0] access_address = AA;
  logic [15:0] search_timeout = 16'd0;
  logic        phy_bit = 1'b0;
  logic        bit_valid = 1'b0;
  logic        busy, aa_hit, info_bit, info_bit_valid, crc_bit_valid;
  logic [15:0] pdu_header;
  logic        header_valid;
  logic [7:0]  payload_len;
  logic        pkt_done, timeout_flag, len_err;

  btle_rx_packet_ctrl #(
    .LEN_UNIQUE_BIT_SEQUENCE(32),
    .MAX_PAYLOAD_BYTES      (37),
    .TIMEOUT_WIDTH          (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .stop           (stop),
    .access_address (access_address),
    .search_timeout (search_timeout),
    .phy_bit        (phy_bit),
    .bit_valid      (bit_valid),
    .busy           (busy),
    .aa_hit         (aa_hit),
    .info_bit       (info_bit),
    .info_bit_valid (info_bit_valid),
    .crc_bit_valid  (crc_bit_valid),
    .pdu_header     (pdu_header),
    .header_valid   (header_valid),
    .payload_len    (payload_len),
    .pkt_done       (pkt_done),
    .timeout_flag   (timeout_flag),
    .len_err        (len_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge.
  logic         mon_clr = 1'b0;
  logic [511:0] info_vec;
  logic [63:0]  crc_vec;
  int n_info, n_crc, n_aa, n_hv, n_done, n_to, n_lerr;
  int aa_cyc, hv_info_at, hv_len, done_crc_at, done_busy, to_busy, lerr_info_at;

  always @(negedge clk) begin
    if (mon_clr) begin
      info_vec <= '0; crc_vec <= '0;
      n_info <= 0; n_crc <= 0; n_aa <= 0; n_hv <= 0; n_done <= 0; n_to <= 0; n_lerr <= 0;
      aa_cyc <= -1; hv_info_at <= -1; hv_len <= -1; done_crc_at <= -1; done_busy <= -1;
      to_busy <= -1; lerr_info_at <= -1;
    end else begin
      if (info_bit_valid) begin
        if (n_info < 512) info_vec[n_info] <= info_bit;
        n_info <= n_info + 1;
      end
      if (crc_bit_valid) begin
        if (n_crc < 64) crc_vec[n_crc] <= info_bit;
        n_crc <= n_crc + 1;
      end
      if (aa_hit) begin
        n_aa   <= n_aa + 1;
        aa_cyc <= cyc;
      end
      if (header_valid) begin
        n_hv       <= n_hv + 1;
        hv_info_at <= n_info + (info_bit_valid ? 1 : 0);
        hv_len     <= int'(payload_len);
      end
      if (pkt_done) begin
        n_done      <= n_done + 1;
        done_crc_at <= n_crc + (crc_bit_valid ? 1 : 0);
        done_busy   <= int'(busy);
      end
      if (timeout_flag) begin
        n_to    <= n_to + 1;
        to_busy <= int'(busy);
      end
      if (len_err) begin
        n_lerr       <= n_lerr + 1;
        lerr_info_at <= n_info + (info_bit_valid ? 1 : 0);
      end
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else begin
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
      $error("%s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    tick();
    mon_clr = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    bit_valid = 1'b0;
    phy_bit   = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  // Sends the low n bits of v LSB-first at full rate; bit_valid stays high afterwards.
  task automatic send_bits(input logic [63:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      phy_bit   = v[i];
      bit_valid = 1'b1;
      tick();
    end
  endtask

  int aa_edge;

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_hdr", 64'(pdu_header), 64'd0);
    check("rst_len", 64'(payload_len), 64'd0);
    check("rst_pulses", 64'({aa_hit, info_bit, info_bit_valid, crc_bit_valid, header_valid,
                             pkt_done, timeout_flag, len_err}), 64'd0);
    rst = 1'b0;
    tick();

    // Full packet: header 0x0502, 5 payload bytes, 24 CRC bits at full rate
    clear_mon();
    do_start();
    check("a_busy_search", 64'(busy), 64'd1);
    send_bits(64'(AA), 32);
    aa_edge = cyc;
    send_bits(64'h0502, 16);
    send_bits(64'h55_44_33_22_11, 40);
    send_bits(64'hABCDEF, 24);
    check("a_busy_at_done", 64'(busy), 64'd0);
    check("a_done_pulse", 64'(pkt_done), 64'd1);
    idle(2);
    check("a_aa_count", 64'(n_aa), 64'd1);
    check("a_aa_latency", 64'(aa_cyc - aa_edge), 64'd1);
    check("a_hv_count", 64'(n_hv), 64'd1);
    check("a_hv_align", 64'(hv_info_at), 64'd16);
    check("a_payload_len", 64'(hv_len), 64'd5);
    check("a_header", 64'(pdu_header), 64'h0502);
    check("a_info_count", 64'(n_info), 64'd56);
    check("a_info_bits", info_vec[63:0], 64'h0000_55_44_33_22_11_0502);
    check("a_crc_count", 64'(n_crc), 64'd24);
    check("a_crc_bits", crc_vec, 64'hABCDEF);
    check("a_done_count", 64'(n_done), 64'd1);
    check("a_done_align", 64'(done_crc_at), 64'd24);
    check("a_done_busy", 64'(done_busy), 64'd0);

    // Search timeout after 100 valid bits, no access address
    clear_mon();
    search_timeout = 16'd100;
    do_start();
    for (int i = 0; i < 99; i++) begin
      phy_bit   = 1'($urandom_range(0, 1));
      bit_valid = 1'b1;
      tick();
    end
    check("to_busy_99", 64'(busy), 64'd1);
    check("to_flag_99", 64'(timeout_flag), 64'd0);
    phy_bit = 1'($urandom_range(0, 1));
    tick();
    check("to_busy_100", 64'(busy), 64'd0);
    idle(2);
    check("to_count", 64'(n_to), 64'd1);
    check("to_flag_busy", 64'(to_busy), 64'd0);
    check("to_no_aa", 64'(n_aa), 64'd0);
    search_timeout = 16'd0;

    // Zero-length payload goes straight to CRC
    clear_mon();
    do_start();
    send_bits(64'(AA), 32);
    send_bits(64'h0001, 16);
    send_bits(64'h123456, 24);
    idle(2);
    check("z_hv", 64'(n_hv), 64'd1);
    check("z_len", 64'(hv_len), 64'd0);
    check("z_info", 64'(n_info), 64'd16);
    check("z_crc", 64'(n_crc), 64'd24);
    check("z_done", 64'(n_done), 64'd1);
    check("z_busy", 64'(busy), 64'd0);

    // Length 40 exceeds the maximum of 37
    clear_mon();
    do_start();
    send_bits(64'(AA), 32);
    send_bits(64'h2802, 16);
    send_bits(64'hFF, 8);
    idle(2);
    check("le_count", 64'(n_lerr), 64'd1);
    check("le_align", 64'(lerr_info_at), 64'd16);
    check("le_info", 64'(n_info), 64'd16);
    check("le_crc", 64'(n_crc), 64'd0);
    check("le_busy", 64'(busy), 64'd0);

    // Length 37 is accepted; stop mid-payload
    clear_mon();
    do_start();
    send_bits(64'(AA), 32);
    send_bits(64'h2500, 16);
    send_bits(64'hF0F0F, 20);
    check("sp_busy_payload", 64'(busy), 64'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("sp_busy_after", 64'(busy), 64'd0);
    idle(2);
    check("sp_no_lerr", 64'(n_lerr), 64'd0);
    check("sp_no_done", 64'(n_done), 64'd0);
    check("sp_header_kept", 64'(pdu_header), 64'h2500);
    check("sp_info_so_far", 64'(n_info), 64'd36);

    // Normal packet after stop
    clear_mon();
    do_start();
    send_bits(64'(AA), 32);
    send_bits(64'h0100, 16);
    send_bits(64'h5A, 8);
    send_bits(64'h0F0F0F, 24);
    idle(2);
    check("sp2_info_bits", info_vec[63:0], 64'h5A_0100);
    check("sp2_info", 64'(n_info), 64'd24);
    check("sp2_done", 64'(n_done), 64'd1);

    // Reset mid-CRC clears everything asynchronously
    clear_mon();
    do_start();
    send_bits(64'(AA), 32);
    send_bits(64'h00A1, 16);
    send_bits(64'h3FF, 10);
    check("rc_crc_before", 64'(crc_bit_valid), 64'd1);
    rst = 1'b1;
    bit_valid = 1'b0;
    #1;
    check("rc_busy_async", 64'(busy), 64'd0);
    check("rc_crc_async", 64'(crc_bit_valid), 64'd0);
    check("rc_hdr_async", 64'(pdu_header), 64'd0);
    tick();
    rst = 1'b0;
    idle(2);
    check("rc_no_done", 64'(n_done), 64'd0);
    clear_mon();
    do_start();
    send_bits(64'(AA), 32);
    send_bits(64'h0000, 16);
    send_bits(64'hC0FFEE, 24);
    idle(2);
    check("rc2_crc", 64'(n_crc), 64'd24);
    check("rc2_done", 64'(n_done), 64'd1);

    // Stale access address: window completes with a single fresh bit
    clear_mon();
    do_start();
    send_bits(64'(AA), 31);
    bit_valid = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    do_start();
    send_bits(64'(AA >> 31), 1);
    idle(3);
    check("st_no_aa", 64'(n_aa), 64'd0);
    check("st_busy", 64'(busy), 64'd1);
    send_bits(64'(AA), 32);
    idle(3);
    check("st_aa_fresh", 64'(n_aa), 64'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    idle(1);
    check("st_stopped", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
